// File: rtl/ad3542_pkg.sv
// Shared types and constants for the AD3542 SPI responder: FSM states,
// register map addresses and counter widths.
package ad3542_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } spi_state_t;

    localparam logic [7:0] CH0_INPUT_16B      = 8'h34;
    localparam logic [7:0] INTERFACE_CONFIG_D = 8'h14;
    localparam logic [7:0] OUTPUT_RANGE       = 8'h19;
    localparam logic [7:0] MULTI_IO           = 8'h0F;

    localparam int ADDR_BITS = 8;
    localparam int REG_BITS  = 8;
    localparam int DATA_BITS = 16;
    localparam int CNT_W     = $clog2(DATA_BITS + 1);
    localparam int PIN_COUNT = 5;

endpackage

// File: rtl/ad3542_spi_target_spi_pin_sync.sv
// Synchronizer chain for the SPI pins and LDAC, with sclk rise and cs
// rise/fall detection on the synchronized copies.
module spi_pin_sync
    import ad3542_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_sclk,
    input  logic i_cs,
    input  logic i_sdio0,
    input  logic i_sdio1,
    input  logic i_ldac,
    output logic o_sclk_rise,
    output logic o_cs_rise,
    output logic o_cs_fall,
    output logic o_cs,
    output logic o_sdio0,
    output logic o_sdio1,
    output logic o_ldac
);

    logic [PIN_COUNT-1:0] r_sync [SYNC_STAGES];
    logic [1:0]           r_prev;
    logic [PIN_COUNT-1:0] w_pins;
    logic [PIN_COUNT-1:0] w_sync;

    assign w_pins = {i_ldac, i_sdio1, i_sdio0, i_cs, i_sclk};
    assign w_sync = r_sync[SYNC_STAGES-1];

    // Left unreset on purpose: the chain always mirrors the pins, so a reset
    // in the middle of a frame cannot fabricate a cs edge afterwards.
    always_ff @(posedge clk) begin
        r_sync[0] <= w_pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
        end
        r_prev <= w_sync[1:0];
    end

    assign o_sclk_rise = w_sync[0] & ~r_prev[0];
    assign o_cs_rise   = w_sync[1] & ~r_prev[1];
    assign o_cs_fall   = ~w_sync[1] & r_prev[1];
    assign o_cs        = w_sync[1];
    assign o_sdio0     = w_sync[2];
    assign o_sdio1     = w_sync[3];
    assign o_ldac      = w_sync[4];

endmodule

// File: rtl/ad3542_spi_target.sv
// SPI responder for the AD3542 link: decodes register writes and DAC frames
// from the master and models the LDAC input/output register pair.
module ad3542_spi_target
    import ad3542_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUAL_ADDR   = INTERFACE_CONFIG_D,
    parameter logic [7:0] DAC_ADDR    = CH0_INPUT_16B
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_sdio0,
    input  logic        spi_sdio1,
    input  logic        ldac,
    input  logic        dev_reset_x,
    output logic        reg_wr_valid,
    output logic [6:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        dac_valid,
    output logic [15:0] dac_in_0,
    output logic [15:0] dac_in_1,
    output logic [15:0] dac_out_0,
    output logic [15:0] dac_out_1,
    output logic        dual_mode,
    output logic        frame_err,
    output logic [15:0] frame_count
);

    logic w_sclk_rise, w_cs_rise, w_cs_fall, w_cs, w_sdio0, w_sdio1, w_ldac;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk         (clk),
        .i_sclk      (spi_sclk),
        .i_cs        (spi_cs),
        .i_sdio0     (spi_sdio0),
        .i_sdio1     (spi_sdio1),
        .i_ldac      (ldac),
        .o_sclk_rise (w_sclk_rise),
        .o_cs_rise   (w_cs_rise),
        .o_cs_fall   (w_cs_fall),
        .o_cs        (w_cs),
        .o_sdio0     (w_sdio0),
        .o_sdio1     (w_sdio1),
        .o_ldac      (w_ldac)
    );

    spi_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0]       r_addr, w_addr_next;
    logic [15:0]      r_sh0, w_sh0_next, r_sh1, w_sh1_next;
    logic             r_overrun, w_overrun_next;
    logic             r_reg_wr_valid, w_reg_wr_valid_next;
    logic [6:0]       r_reg_wr_addr, w_reg_wr_addr_next;
    logic [7:0]       r_reg_wr_data, w_reg_wr_data_next;
    logic             r_dac_valid, w_dac_valid_next;
    logic [15:0]      r_dac_in_0, w_dac_in_0_next, r_dac_in_1, w_dac_in_1_next;
    logic [15:0]      r_dac_out_0, w_dac_out_0_next, r_dac_out_1, w_dac_out_1_next;
    logic             r_dual_mode, w_dual_mode_next;
    logic             r_frame_err, w_frame_err_next;
    logic [15:0]      r_frame_count;
    logic             w_sample, w_is_reg_wr, w_is_dac_wr, w_accept;

    assign w_sample    = w_sclk_rise & ~w_cs;
    assign w_is_reg_wr = (r_state == ST_DATA) && !r_overrun && !r_addr[7]
                         && (r_bit_cnt == CNT_W'(REG_BITS)) && (r_addr != DAC_ADDR);
    assign w_is_dac_wr = (r_state == ST_DATA) && !r_overrun && !r_addr[7]
                         && (r_bit_cnt == CNT_W'(DATA_BITS)) && (r_addr == DAC_ADDR);
    assign w_accept    = w_cs_rise & (w_is_reg_wr | w_is_dac_wr);

    always_comb begin
        w_state_next        = r_state;
        w_bit_cnt_next      = r_bit_cnt;
        w_addr_next         = r_addr;
        w_sh0_next          = r_sh0;
        w_sh1_next          = r_sh1;
        w_overrun_next      = r_overrun;
        w_reg_wr_valid_next = 1'b0;
        w_reg_wr_addr_next  = r_reg_wr_addr;
        w_reg_wr_data_next  = r_reg_wr_data;
        w_dac_valid_next    = 1'b0;
        w_dac_in_0_next     = r_dac_in_0;
        w_dac_in_1_next     = r_dac_in_1;
        w_dual_mode_next    = r_dual_mode;
        w_frame_err_next    = 1'b0;

        if (w_cs_fall) begin
            // A fall while busy means the previous cs rise was never seen.
            w_frame_err_next = (r_state != ST_IDLE);
            w_state_next     = ST_ADDR;
            w_bit_cnt_next   = '0;
            w_overrun_next   = 1'b0;
        end else if (w_cs_rise) begin
            w_state_next = ST_IDLE;
            if (w_is_reg_wr) begin
                w_reg_wr_valid_next = 1'b1;
                w_reg_wr_addr_next  = r_addr[6:0];
                w_reg_wr_data_next  = r_sh0[7:0];
                if (r_addr == DUAL_ADDR) begin
                    w_dual_mode_next = (r_sh0[2:1] == 2'b11);
                end
            end else if (w_is_dac_wr) begin
                w_dac_valid_next = 1'b1;
                w_dac_in_0_next  = r_sh0;
                if (r_dual_mode) begin
                    w_dac_in_1_next = r_sh1;
                end
            end else if (r_state != ST_IDLE) begin
                w_frame_err_next = 1'b1;
            end
        end else if (w_sample) begin
            case (r_state)
                ST_ADDR: begin
                    w_addr_next = {r_addr[6:0], w_sdio0};
                    if (r_bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                        w_state_next   = ST_DATA;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == CNT_W'(DATA_BITS)) begin
                        w_overrun_next = 1'b1;
                    end else begin
                        w_sh0_next     = {r_sh0[14:0], w_sdio0};
                        w_sh1_next     = {r_sh1[14:0], w_sdio1};
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Output registers follow the post-commit input value so a DAC commit
        // coinciding with LDAC lands in dac_out the same cycle.
        w_dac_out_0_next = w_ldac ? r_dac_out_0 : w_dac_in_0_next;
        w_dac_out_1_next = w_ldac ? r_dac_out_1 : w_dac_in_1_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_x || !dev_reset_x) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_addr         <= '0;
            r_sh0          <= '0;
            r_sh1          <= '0;
            r_overrun      <= 1'b0;
            r_reg_wr_valid <= 1'b0;
            r_reg_wr_addr  <= '0;
            r_reg_wr_data  <= '0;
            r_dac_valid    <= 1'b0;
            r_dac_in_0     <= '0;
            r_dac_in_1     <= '0;
            r_dac_out_0    <= '0;
            r_dac_out_1    <= '0;
            r_dual_mode    <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_bit_cnt      <= w_bit_cnt_next;
            r_addr         <= w_addr_next;
            r_sh0          <= w_sh0_next;
            r_sh1          <= w_sh1_next;
            r_overrun      <= w_overrun_next;
            r_reg_wr_valid <= w_reg_wr_valid_next;
            r_reg_wr_addr  <= w_reg_wr_addr_next;
            r_reg_wr_data  <= w_reg_wr_data_next;
            r_dac_valid    <= w_dac_valid_next;
            r_dac_in_0     <= w_dac_in_0_next;
            r_dac_in_1     <= w_dac_in_1_next;
            r_dac_out_0    <= w_dac_out_0_next;
            r_dac_out_1    <= w_dac_out_1_next;
            r_dual_mode    <= w_dual_mode_next;
            r_frame_err    <= w_frame_err_next;
        end
    end

    // The frame counter survives the emulated device reset.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            r_frame_count <= '0;
        end else if (dev_reset_x && w_accept) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign reg_wr_valid = r_reg_wr_valid;
    assign reg_wr_addr  = r_reg_wr_addr;
    assign reg_wr_data  = r_reg_wr_data;
    assign dac_valid    = r_dac_valid;
    assign dac_in_0     = r_dac_in_0;
    assign dac_in_1     = r_dac_in_1;
    assign dac_out_0    = r_dac_out_0;
    assign dac_out_1    = r_dac_out_1;
    assign dual_mode    = r_dual_mode;
    assign frame_err    = r_frame_err;
    assign frame_count  = r_frame_count;

endmodule

// File: doc/ad3542_spi_target.md
# ad3542_spi_target

Synthesizable SPI responder for the AD3542 link: decodes the frames our DAC master drives (8-bit address on sdio0, then 8-bit register data or 16-bit DAC codes on one or two lanes) and presents them as register-write and DAC-update strobes. It runs in the same `clk` domain as the master. It serves as an on-board loopback checker and DAC emulator, with a model of the LDAC input/output register pair.

## Interface
- `SYNC_STAGES`, 2: input register depth on all SPI pins (≥1).
- `DUAL_ADDR`, 8'h14: register address whose writes control dual-lane mode.
- `DAC_ADDR`, 8'h34: CH0_INPUT_16B streaming address.
- `clk` in 1: system clock; SPI pins sampled here; sclk high and low phases each ≥1 clk.
- `reset_x` in 1: synchronous, active-low reset.
- `spi_sclk`, `spi_cs`, `spi_sdio0`, `spi_sdio1` in 1 each: SPI bus as driven by the master.
- `ldac` in 1: active-low load strobe.
- `dev_reset_x` in 1: emulated device reset (active-low); when low, same clear as `reset_x` except `frame_count`.
- `reg_wr_valid` out 1: one-cycle pulse per accepted 8-bit register write.
- `reg_wr_addr` out 7, `reg_wr_data` out 8: write payload; held until the next write.
- `dac_valid` out 1: one-cycle pulse per accepted DAC frame.
- `dac_in_0`, `dac_in_1` out 16 each: input registers.
- `dac_out_0`, `dac_out_1` out 16 each: output registers, loaded on LDAC.
- `dual_mode` out 1: current lane mode.
- `frame_err` out 1: one-cycle pulse on a malformed or rejected frame.
- `frame_count` out 16: count of accepted frames; wraps.

## Operation
- Pins pass through `SYNC_STAGES` flops. Edge detect runs on the synchronized copies: sclk rise, cs fall, cs rise.
- Data is sampled on the sclk rise while cs is low. sclk edges with cs high are ignored.
- State machine:
  - IDLE → ADDR on cs fall. The bit counter clears.
  - ADDR: shift sdio0 MSB first for 8 bits. Bit7 is R/W (1 = read).
  - DATA: shift sdio0 into `sh0` and sdio1 into `sh1`, MSB first, up to 16 bits. Extra bits set an `overrun` flag.
  - Any state → IDLE on cs rise, after commit/reject.
- Commit at cs rise:
  - Data bits = 8, address ≠ DAC_ADDR, R/W = 0: register write. `reg_wr_valid` pulses with `reg_wr_addr` = addr[6:0] and `reg_wr_data` = sh0[7:0].
  - If that address equals DUAL_ADDR: `dual_mode` ← (data[2:1] == 2'b11).
  - Data bits = 16, address = DAC_ADDR, R/W = 0: `dac_in_0` ← sh0. If `dual_mode` = 1, `dac_in_1` ← sh1; otherwise `dac_in_1` is unchanged. `dac_valid` pulses.
  - Any other case: reject. `frame_err` pulses; no register, mode or count change. This covers R/W = 1, short address, wrong data length, overrun, and cs rise in ADDR.
- `frame_count` increments on every accepted frame and wraps 0xFFFF → 0.
- LDAC: on any cycle where synchronized `ldac` = 0, `dac_out_x` ← `dac_in_x`. Holding ldac low keeps the registers transparent.
- If ldac is low in the same cycle as a DAC commit, `dac_out` takes the newly committed value (bypass).
- cs fall while not IDLE (glitch): restart ADDR and pulse `frame_err`.
- `dev_reset_x` low: all outputs go to reset values and the FSM returns to IDLE. A frame in progress is discarded without `frame_err`.

## Timing
- Reset values:
  - All pulses 0.
  - `reg_wr_addr`/`reg_wr_data` 0.
  - `dac_in`/`dac_out` 16'h0000.
  - `dual_mode` 0.
  - `frame_count` 0 (`reset_x` only).
  - FSM IDLE.
- Commit latency: `reg_wr_valid`/`dac_valid`/`frame_err` rise `SYNC_STAGES`+1 clk after the cs rise at the pins.
- LDAC latency: `dac_out` updates `SYNC_STAGES`+1 clk after ldac falls at the pin.
- Pulses are exactly 1 clk wide. Back-to-back frames need cs high for ≥1 synchronized clk.
- `reset_x` low mid-frame: all state clears next clk, no pulses.

## Structure
- Package `ad3542_pkg`:
  - FSM enum (IDLE, ADDR, DATA).
  - Localparams: CH0_INPUT_16B = 8'h34, INTERFACE_CONFIG_D = 8'h14, OUTPUT_RANGE = 8'h19, MULTI_IO = 8'h0F.
  - Bit-count widths.
- Sub-module `spi_pin_sync`: parameterized synchronizer plus rise/fall detect for sclk/cs, and delayed sdio0/sdio1/ldac. Instantiated once.

## Test plan
- Write 0x19 / data 0x33, 8 data bits → one `reg_wr_valid`; addr 0x19, data 0x33; `frame_count` = 1; `dual_mode` stays 0.
- Write 0x14 / data 0x06 → `dual_mode` = 1. Then a frame to 0x34 with lane0 = 16'h1230, lane1 = 16'hABC0 → `dac_valid`, `dac_in` = 1230/ABC0, `dac_out` still 0. Then an ldac low pulse → `dac_out` = 1230/ABC0 after `SYNC_STAGES`+1 clk.
- Same DAC frame with `dual_mode` = 0 → `dac_in_0` = 1230, `dac_in_1` unchanged.
- ldac low in the same cycle as cs rise on a DAC frame → `dac_out` shows the new codes at commit time.
- Error cases, each → `frame_err` pulse only, no outputs changed:
  - Address with bit7 set (0x94).
  - cs rise after 5 address bits.
  - 12-bit data frame to 0x34.
  - 17 data bits.
- `reset_x` low mid-DATA → no pulses, all outputs 0. The next complete frame decodes correctly.
